// File: rtl/cgra_seq_pkg.sv
// Shared definitions for the CGRA context sequencer: FSM state encoding,
// command opcodes and default array dimensions.
package cgra_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    localparam logic CMD_LOAD = 1'b0;
    localparam logic CMD_RUN  = 1'b1;

    localparam int DEF_WIDTH     = 120;
    localparam int DEF_NUM_PE    = 16;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_DRAIN_CYC = 4;

endpackage

// File: rtl/cgra_cfg_addr_gen.sv
// Nested PE/context counters. In load mode the PE index is the inner loop
// (context-major word order); in run mode only the context pointer advances
// and wraps after ctx_last.
module cgra_cfg_addr_gen
    import cgra_seq_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     step,
    input  logic                     run_mode,
    input  logic [$clog2(DEPTH)-1:0] ctx_last,
    output logic [NUM_PE-1:0]        pe_onehot,
    output logic [$clog2(DEPTH)-1:0] ctx,
    output logic                     last
);
    localparam int PE_W  = $clog2(NUM_PE);
    localparam int CTX_W = $clog2(DEPTH);
    localparam logic [PE_W-1:0] PE_MAX = PE_W'(NUM_PE - 1);

    logic [PE_W-1:0]  pe_r;
    logic [CTX_W-1:0] ctx_r;
    logic             pe_wrap_s;
    logic             ctx_hit_s;

    // Decode the counters into the one-hot PE select and end-of-sequence flag.
    always_comb begin
        pe_wrap_s = (pe_r == PE_MAX);
        ctx_hit_s = (ctx_r == ctx_last);
        pe_onehot = {{(NUM_PE-1){1'b0}}, 1'b1} << pe_r;
        ctx       = ctx_r;
        if (run_mode) begin
            last = ctx_hit_s;
        end else begin
            last = pe_wrap_s && ctx_hit_s;
        end
    end

    // Advance the PE-inner/context-outer counters, or the wrapping run pointer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pe_r  <= {PE_W{1'b0}};
            ctx_r <= {CTX_W{1'b0}};
        end else if (step && run_mode) begin
            pe_r <= {PE_W{1'b0}};
            if (ctx_hit_s) begin
                ctx_r <= {CTX_W{1'b0}};
            end else begin
                ctx_r <= ctx_r + CTX_W'(1);
            end
        end else if (step) begin
            if (pe_wrap_s) begin
                pe_r  <= {PE_W{1'b0}};
                ctx_r <= ctx_r + CTX_W'(1);
            end else begin
                pe_r  <= pe_r + PE_W'(1);
                ctx_r <= ctx_r;
            end
        end else begin
            pe_r  <= pe_r;
            ctx_r <= ctx_r;
        end
    end

endmodule

// File: rtl/cgra_ctx_sequencer.sv
// Array-level controller: streams context words into the PE caches (LOAD),
// then broadcasts start / context pointer / commit strobes for a programmed
// number of schedule iterations (RUN), followed by a fixed drain period.
module cgra_ctx_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_PE    = DEF_NUM_PE,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [$clog2(DEPTH):0]   cmd_len,
    input  logic [15:0]              cmd_iter,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [WIDTH:0]           cfg_data,
    input  logic                     abort,
    output logic [NUM_PE-1:0]        pe_we,
    output logic [$clog2(DEPTH)-1:0] pe_addr,
    output logic [WIDTH:0]           pe_data,
    output logic                     pe_start,
    output logic [$clog2(DEPTH)-1:0] pe_cp,
    output logic                     pe_ld_write,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int CTX_W   = $clog2(DEPTH);
    localparam int DRAIN_W = $clog2(DRAIN_CYC) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [CTX_W:0]     LEN_MAX    = (CTX_W+1)'(DEPTH);

    seq_state_e         state_r, state_next;
    logic [CTX_W-1:0]   len_m1_r, len_m1_next;
    logic [15:0]        iter_r, iter_next;
    logic [DRAIN_W-1:0] drain_r, drain_next;
    logic               load_fin_r, load_fin_next;
    logic               done_r, done_next;
    logic               err_r, err_next;
    logic [NUM_PE-1:0]  pe_we_r;
    logic [CTX_W-1:0]   pe_addr_r;
    logic [WIDTH:0]     pe_data_r;

    logic               cmd_acc_s, len_ok_s, cfg_acc_s;
    logic               ag_clear_s, ag_step_s, ag_run_s, ag_last_s;
    logic [NUM_PE-1:0]  ag_onehot_s;
    logic [CTX_W-1:0]   ag_ctx_s;

    cgra_cfg_addr_gen #(
        .NUM_PE (NUM_PE),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk       (CLK),
        .rst       (RST),
        .clear     (ag_clear_s),
        .step      (ag_step_s),
        .run_mode  (ag_run_s),
        .ctx_last  (len_m1_r),
        .pe_onehot (ag_onehot_s),
        .ctx       (ag_ctx_s),
        .last      (ag_last_s)
    );

    // Status and broadcast strobes decoded from registered state only.
    always_comb begin
        cmd_ready   = (state_r == ST_IDLE);
        cfg_ready   = (state_r == ST_LOAD) && !load_fin_r;
        busy        = (state_r != ST_IDLE);
        pe_start    = (state_r == ST_RUN);
        pe_ld_write = (state_r == ST_RUN) && (iter_r == 16'd1);
        if (state_r == ST_RUN) begin
            pe_cp = ag_ctx_s;
        end else begin
            pe_cp = {CTX_W{1'b0}};
        end
        pe_we   = pe_we_r;
        pe_addr = pe_addr_r;
        pe_data = pe_data_r;
        done    = done_r;
        err     = err_r;
    end

    // Next-state logic: command decode, load progress, run iterations, drain.
    always_comb begin
        state_next    = state_r;
        len_m1_next   = len_m1_r;
        iter_next     = iter_r;
        drain_next    = drain_r;
        load_fin_next = load_fin_r;
        done_next     = 1'b0;
        err_next      = 1'b0;
        ag_clear_s    = 1'b0;
        ag_step_s     = 1'b0;
        ag_run_s      = (state_r == ST_RUN);
        cmd_acc_s     = cmd_valid && (state_r == ST_IDLE);
        len_ok_s      = (cmd_len != {(CTX_W+1){1'b0}}) && (cmd_len <= LEN_MAX);
        // abort wins over a simultaneous handshake: the word is not written
        cfg_acc_s     = cfg_valid && cfg_ready && !abort;
        case (state_r)
            ST_IDLE: begin
                if (cmd_acc_s && !len_ok_s) begin
                    err_next = 1'b1;
                end else if (cmd_acc_s) begin
                    ag_clear_s    = 1'b1;
                    load_fin_next = 1'b0;
                    len_m1_next   = CTX_W'(cmd_len - (CTX_W+1)'(1));
                    if (cmd_op == CMD_LOAD) begin
                        state_next = ST_LOAD;
                    end else if (cmd_iter == 16'd0) begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_INIT;
                    end else begin
                        state_next = ST_RUN;
                        iter_next  = cmd_iter;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (load_fin_r) begin
                    // last write is on the port this cycle; done follows it
                    state_next    = ST_IDLE;
                    done_next     = 1'b1;
                    load_fin_next = 1'b0;
                end else if (cfg_acc_s) begin
                    ag_step_s     = 1'b1;
                    load_fin_next = ag_last_s;
                end else begin
                    ag_step_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    ag_step_s = 1'b1;
                    if (ag_last_s && (iter_r == 16'd1)) begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_INIT;
                        iter_next  = 16'd0;
                    end else if (ag_last_s) begin
                        iter_next = iter_r - 16'd1;
                    end else begin
                        iter_next = iter_r;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (drain_r == {DRAIN_W{1'b0}}) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_next = drain_r - DRAIN_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, iteration/drain counters, pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            len_m1_r   <= {CTX_W{1'b0}};
            iter_r     <= 16'd0;
            drain_r    <= {DRAIN_W{1'b0}};
            load_fin_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next;
            len_m1_r   <= len_m1_next;
            iter_r     <= iter_next;
            drain_r    <= drain_next;
            load_fin_r <= load_fin_next;
            done_r     <= done_next;
            err_r      <= err_next;
        end
    end

    // Registered cache write port: exactly one write per accepted word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pe_we_r   <= {NUM_PE{1'b0}};
            pe_addr_r <= {CTX_W{1'b0}};
            pe_data_r <= {(WIDTH+1){1'b0}};
        end else if (cfg_acc_s) begin
            pe_we_r   <= ag_onehot_s;
            pe_addr_r <= ag_ctx_s;
            pe_data_r <= cfg_data;
        end else begin
            pe_we_r   <= {NUM_PE{1'b0}};
            pe_addr_r <= pe_addr_r;
            pe_data_r <= pe_data_r;
        end
    end

endmodule
